cyc_measure: RTL

CYC_MEASURE -- requirements
Module: cyc_measure

---
 rtl/cyc_measure_pkg.sv | 17 +
 rtl/cyc_measure.sv | 134 +++++++++++++
 2 files changed

// File: rtl/cyc_measure_pkg.sv
// cyc_measure_pkg: shared types and default constants for cyc_measure.
//   state_t      - measurement FSM states
//   *_DEF        - default parameter values for the cyc_measure top
package cyc_measure_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    MEAS = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned N_BITS_DEF  = 8;
  localparam int unsigned RST_CYC_DEF = 2;
  localparam int unsigned TIMEOUT_DEF = 200;

endpackage

// File: rtl/cyc_measure.sv
// cyc_measure: measures how many cycles an external device needs after being
// reset until it asserts its active-low done flag.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   request a measurement (honoured only while idle)
//   done_n   in   active-low done flag from the measured device
//   dut_rst  out  registered reset pulse (RST_CYC cycles) to the device
//   busy     out  high whenever a measurement is in progress
//   meas     out  measured cycle count, held until the next accepted start
//   valid    out  one-cycle pulse when meas holds a completed measurement
//   timeout  out  sticky flag: the last measurement hit TIMEOUT and aborted
module cyc_measure
  import cyc_measure_pkg::*;
#(
  parameter int unsigned N_BITS  = N_BITS_DEF,
  parameter int unsigned RST_CYC = RST_CYC_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              done_n,
  output logic              dut_rst,
  output logic              busy,
  output logic [N_BITS-1:0] meas,
  output logic              valid,
  output logic              timeout
);

  localparam logic [N_BITS-1:0] MEAS_LAST = N_BITS'(TIMEOUT - 1);
  localparam logic [7:0]        RST_LAST  = 8'(RST_CYC - 1);

  state_t            state;
  state_t            state_nx;
  logic [7:0]        rst_cnt;
  logic [7:0]        rst_cnt_nx;
  logic [N_BITS-1:0] meas_nx;
  logic              timeout_nx;
  logic              dut_rst_nx;
  logic              busy_nx;
  logic              valid_nx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RST;
        end
      end
      RST: begin
        if (rst_cnt == RST_LAST) begin
          state_nx = MEAS;
        end
      end
      MEAS: begin
        if (!done_n) begin
          state_nx = DONE;
        end else if (meas == MEAS_LAST) begin
          state_nx = IDLE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Output / datapath next values. Flag outputs are decoded from the next
  // state so that the registered copies line up with the state they describe.
  always_comb begin
    rst_cnt_nx = rst_cnt;
    meas_nx    = meas;
    timeout_nx = timeout;
    dut_rst_nx = (state_nx == RST);
    busy_nx    = (state_nx != IDLE);
    valid_nx   = (state_nx == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          rst_cnt_nx = '0;
          meas_nx    = '0;
          timeout_nx = 1'b0;
        end
      end
      RST: begin
        rst_cnt_nx = rst_cnt + 8'd1;
      end
      MEAS: begin
        if (done_n) begin
          meas_nx = meas + N_BITS'(1);
          if (meas == MEAS_LAST) begin
            timeout_nx = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_cnt <= '0;
      meas    <= '0;
      timeout <= 1'b0;
      dut_rst <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      rst_cnt <= rst_cnt_nx;
      meas    <= meas_nx;
      timeout <= timeout_nx;
      dut_rst <= dut_rst_nx;
      busy    <= busy_nx;
      valid   <= valid_nx;
    end
  end

endmodule
